local_sacc: RTL
===============

Name: local_sacc

Overview:
- Bit-serial shift-and-accumulate stage directly downstream of the local MAC array.
- Activations enter the MAC array one bit-plane per cycle, MSB first. The MAC array produces one 12-bit partial sum per bit-plane.
- This block weights each partial sum by its bit significance and accumulates IN_BITS beats into one full-precision dot-product result.
- The result is presented on a valid/ready output handshake towards the global reduction/readout logic.

Parameters:
- MAC_W, 12, width of incoming partial sum (mac_out of MAC array).
- IN_BITS, 8, activation precision = number of bit-plane beats per result; must be >= 2.
- ACC_W, MAC_W+IN_BITS, accumulator/result width; the full range is representable, no overflow handling required.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new accumulation; honoured only in IDLE, or in DONE in the same cycle as the output handshake.
- in_signed  input  1  activations are two's complement (MSB plane has weight -2^(IN_BITS-1)); latched on accepted start.
- sus  input  1  partial sums are signed (1 = sign-extend mac_in, 0 = zero-extend); sampled per accepted beat.
- mac_valid  input  1  mac_in holds a valid bit-plane partial sum.
- mac_in  input  MAC_W  partial sum from the MAC array.
- mac_ready  output  1  block accepts a beat; equals (state==ACC).
- busy  output  1  state != IDLE.
- out_valid  output  1  result available; equals (state==DONE).
- out_ready  input  1  consumer accepts result.
- acc_out  output  ACC_W  accumulated result; held stable while out_valid.

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, bit_cnt=0, in_signed_q=0. Outputs: mac_ready=0, busy=0, out_valid=0, acc_out=0.
- States and transitions:
  - IDLE: on start -> ACC, acc<=0, bit_cnt<=0, in_signed_q<=in_signed.
  - ACC: a beat is accepted when mac_valid&mac_ready.
  - Beat arithmetic: p = sus ? sign-extend(mac_in) : zero-extend(mac_in), extended to ACC_W.
    - bit_cnt==0 (MSB plane): acc <= in_signed_q ? -p : p.
    - Otherwise: acc <= (acc<<1) + p.
    - bit_cnt increments on each accepted beat.
  - Completion: on the beat with bit_cnt==IN_BITS-1 -> DONE, with the final acc visible on acc_out in the next cycle. Latency from last beat to out_valid = 1 cycle.
  - Cycles with mac_valid=0 in ACC are bubbles: no state change, no count.
  - start asserted while in ACC is ignored.
  - DONE: acc_out and out_valid are held until out_ready.
    - out_valid&out_ready -> IDLE.
    - If start is also 1 in that cycle -> ACC directly, with acc/bit_cnt cleared and in_signed latched.
  - mac_valid in IDLE/DONE is ignored (mac_ready=0); the upstream must hold its data.
- acc_out is driven from the acc register; its value is only meaningful while out_valid=1.
- rst asserted mid-ACC or mid-DONE aborts immediately. Partial results are discarded and the block returns to its reset values.
- All arithmetic is two's complement, modulo 2^ACC_W.

Optional Feature:
- Macro: LOCAL_SACC_BIAS_EN.
- Defined:
  - Adds input port bias (ACC_W bits, two's complement), latched on accepted start.
  - The final beat computes acc <= (acc<<1) + p + bias_q, so acc_out = dot + bias.
  - bias_q resets to 0.
- Undefined: no bias port, no bias register; acc_out = dot product only.

Test Plan:
- Unsigned accumulate: in_signed=0, sus=0, start, 8 beats mac_in=1 -> out_valid one cycle after beat 8, acc_out=255 (0x000FF).
- Signed activation MSB: in_signed=1, sus=0, beats 5,0,0,0,0,0,0,0 -> acc_out=-640 (0xFFD80). Repeat with in_signed=0 -> 640 (0x00280).
- Signed partial sums: in_signed=0, sus=1, 8 beats mac_in=12'hFFF -> acc_out=-255 (0xFFF01). With sus=0, same data -> 4095*255=1044225 (0xFEF01).
- Bubbles and backpressure:
  - mac_valid toggles 1/0 across 16 cycles -> exactly 8 beats counted, same result as the all-ones case.
  - In DONE, out_ready=0 for 5 cycles with mac_valid pulsing -> acc_out/out_valid held, mac_ready=0, no change.
  - out_ready=1 -> IDLE next cycle.
- Back-to-back: in DONE, assert out_ready=1 and start=1 together -> next cycle ACC, busy=1, out_valid=0. The next 8 beats of value 2 -> acc_out=510.
- Reset/abort: after 3 accepted beats assert rst for 1 cycle -> IDLE, acc_out=0, out_valid=0, busy=0. start during ACC is ignored (count continues). With LOCAL_SACC_BIAS_EN, bias=-255 on test 1 -> acc_out=0.

Source files
------------

// File: rtl/local_sacc_if.sv
// local_sacc_if: MAC beat input, result output and control bundle for local_sacc (bias port only with LOCAL_SACC_BIAS_EN)
interface local_sacc_if #(
    parameter int MAC_W   = 12,
    parameter int IN_BITS = 8,
    parameter int ACC_W   = MAC_W + IN_BITS
);
    logic             start;
    logic             in_signed;
    logic             sus;
    logic             mac_valid;
    logic [MAC_W-1:0] mac_in;
    logic             mac_ready;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
`ifdef LOCAL_SACC_BIAS_EN
    logic [ACC_W-1:0] bias;
    modport master (output start, in_signed, sus, mac_valid, mac_in, out_ready, bias,
                    input mac_ready, busy, out_valid, acc_out);
    modport slave  (input start, in_signed, sus, mac_valid, mac_in, out_ready, bias,
                    output mac_ready, busy, out_valid, acc_out);
`else
    modport master (output start, in_signed, sus, mac_valid, mac_in, out_ready,
                    input mac_ready, busy, out_valid, acc_out);
    modport slave  (input start, in_signed, sus, mac_valid, mac_in, out_ready,
                    output mac_ready, busy, out_valid, acc_out);
`endif
endinterface

// File: rtl/local_sacc.sv
// local_sacc: bit-serial MSB-first shift-and-accumulate of MAC partial sums (optional bias via LOCAL_SACC_BIAS_EN)
module local_sacc #(
    parameter int MAC_W   = 12,
    parameter int IN_BITS = 8,
    parameter int ACC_W   = MAC_W + IN_BITS
) (
    input logic         clk,
    input logic         rst,
    local_sacc_if.slave bus
);
    localparam int CW = $clog2(IN_BITS);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic             in_signed_q;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] p;
    logic [ACC_W-1:0] nxt;
    logic             last;
    logic             take;
`ifdef LOCAL_SACC_BIAS_EN
    logic [ACC_W-1:0] bias_q;
`endif
    // Extend the beat, weight it against the running sum; the MSB plane carries the sign weight
    always_comb begin
        p = bus.sus ? {{(ACC_W-MAC_W){bus.mac_in[MAC_W-1]}}, bus.mac_in}
                    : {{(ACC_W-MAC_W){1'b0}}, bus.mac_in};
        last = bit_cnt == CW'(IN_BITS - 1);
`ifdef LOCAL_SACC_BIAS_EN
        nxt = bit_cnt == '0 ? (in_signed_q ? -p : p) : (acc << 1) + p + (last ? bias_q : '0);
`else
        nxt = bit_cnt == '0 ? (in_signed_q ? -p : p) : (acc << 1) + p;
`endif
        take = bus.start && (state == IDLE || (state == DONE && bus.out_ready));
    end
    // Control FSM and accumulator: start, beat acceptance, completion and result handoff
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            bit_cnt     <= '0;
            in_signed_q <= 1'b0;
`ifdef LOCAL_SACC_BIAS_EN
            bias_q      <= '0;
`endif
        end else if (take) begin
            state       <= ACC;
            acc         <= '0;
            bit_cnt     <= '0;
            in_signed_q <= bus.in_signed;
`ifdef LOCAL_SACC_BIAS_EN
            bias_q      <= bus.bias;
`endif
        end else if (state == ACC && bus.mac_valid) begin
            acc     <= nxt;
            bit_cnt <= bit_cnt + CW'(1);
            state   <= last ? DONE : ACC;
        end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
        end
    end
    assign bus.mac_ready = state == ACC;
    assign bus.busy      = state != IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.acc_out   = acc;
endmodule
